// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode constants: instruction field positions, HALT opcode and fetch state encoding.
package instr_fetch_unit_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int FUNCT_MSB  = 3;
  localparam int FUNCT_LSB  = 0;

  localparam logic [4:0] OPCODE_HALT = 5'b11111;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

  function automatic logic [4:0] get_opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [3:0] get_funct(input logic [31:0] word);
    return word[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/ifu_prefetch_buf.sv
// One-entry instruction + PC holding slot; only built when IFU_PREFETCH_EN is defined.
`ifdef IFU_PREFETCH_EN
module ifu_prefetch_buf #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              pop,
  input  logic [31:0]       din_instr,
  input  logic [ADDR_W-1:0] din_pc,
  output logic              vld,
  output logic [31:0]       dout_instr,
  output logic [ADDR_W-1:0] dout_pc
);

  // load beats pop so a same-cycle refill keeps the slot occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld        <= 1'b0;
      dout_instr <= '0;
      dout_pc    <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld        <= 1'b1;
      dout_instr <= din_instr;
      dout_pc    <= din_pc;
    end else if (pop) begin
      vld <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, req/ack instruction fetch, valid/ready hand-off to decode, redirect and HALT.
// Optional one-entry prefetch buffer enabled by defining IFU_PREFETCH_EN.
//
// state    | meaning
// ST_FETCH | latch PC into fetch address, request goes out next cycle
// ST_WAIT  | mem_req high, waiting for mem_ack
// ST_HOLD  | instruction presented (prefetch: fetch paused for space/HALT)
// ST_DRAIN | redirected mid-fetch; swallow the outstanding response
// ST_HALT  | HALT transferred; idle until redirect
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [4:0]        opcode,
  output logic [3:0]        funct,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
  logic [ADDR_W-1:0] ipc_q, ipc_nxt;
  logic [31:0]       instr_q, instr_nxt;
  logic              out_vld, out_vld_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              halt_out;

  assign pc_inc   = pc + ADDR_W'(PC_STEP);
  assign halt_out = (get_opcode(instr_q) == OPCODE_HALT);

`ifdef IFU_PREFETCH_EN
  logic              buf_vld, buf_load, buf_pop;
  logic [31:0]       buf_instr;
  logic [ADDR_W-1:0] buf_pc;
  logic              xfer, arrive, halt_pend;
  logic [1:0]        occ_after;

  assign xfer      = out_vld & instr_ready & ~redirect_valid;
  assign arrive    = (state == ST_WAIT) & mem_ack & ~redirect_valid;
  assign occ_after = 2'(out_vld) + 2'(buf_vld) - 2'(xfer) + 2'(arrive);
  assign halt_pend = (out_vld & halt_out) |
                     (buf_vld & (get_opcode(buf_instr) == OPCODE_HALT));

  ifu_prefetch_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (buf_load),
    .pop        (buf_pop),
    .din_instr  (mem_rdata),
    .din_pc     (pc),
    .vld        (buf_vld),
    .dout_instr (buf_instr),
    .dout_pc    (buf_pc)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      ipc_q      <= '0;
      instr_q    <= '0;
      out_vld    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetch_addr <= fetch_addr_nxt;
      ipc_q      <= ipc_nxt;
      instr_q    <= instr_nxt;
      out_vld    <= out_vld_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_addr_nxt = fetch_addr;
    ipc_nxt        = ipc_q;
    instr_nxt      = instr_q;
    out_vld_nxt    = out_vld;
`ifdef IFU_PREFETCH_EN
    buf_load = 1'b0;
    buf_pop  = 1'b0;
    // Presentation slot: buffered word first, then a fresh response.
    if (xfer) begin
      if (buf_vld) begin
        instr_nxt = buf_instr;
        ipc_nxt   = buf_pc;
        buf_pop   = 1'b1;
        buf_load  = arrive;
      end else if (arrive) begin
        instr_nxt = mem_rdata;
        ipc_nxt   = pc;
      end else begin
        out_vld_nxt = 1'b0;
      end
    end else if (arrive) begin
      if (out_vld) begin
        buf_load = 1'b1;
      end else begin
        instr_nxt   = mem_rdata;
        ipc_nxt     = pc;
        out_vld_nxt = 1'b1;
      end
    end
    case (state)
      ST_FETCH: begin
        fetch_addr_nxt = pc;
        state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          pc_nxt = pc_inc;
          if (get_opcode(mem_rdata) != OPCODE_HALT && occ_after <= 2'd1)
            fetch_addr_nxt = pc_inc;
          else
            state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (xfer && halt_out)
          state_nxt = ST_HALT;
        else if (!halt_pend && occ_after <= 2'd1)
          state_nxt = ST_FETCH;
      end
      ST_DRAIN: begin
        if (mem_ack) state_nxt = ST_FETCH;
      end
      default: ;
    endcase
`else
    case (state)
      ST_FETCH: begin
        fetch_addr_nxt = pc;
        state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          instr_nxt   = mem_rdata;
          ipc_nxt     = pc;
          pc_nxt      = pc_inc;
          out_vld_nxt = 1'b1;
          state_nxt   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          out_vld_nxt = 1'b0;
          state_nxt   = halt_out ? ST_HALT : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) state_nxt = ST_FETCH;
      end
      default: ;
    endcase
`endif
    // Redirect overrides everything; an outstanding request must still be drained.
    if (redirect_valid) begin
      pc_nxt         = redirect_pc;
      fetch_addr_nxt = fetch_addr;
      ipc_nxt        = ipc_q;
      instr_nxt      = instr_q;
      out_vld_nxt    = 1'b0;
      state_nxt      = ((state == ST_WAIT || state == ST_DRAIN) && !mem_ack) ?
                       ST_DRAIN : ST_FETCH;
    end
  end

  assign mem_req     = (state == ST_WAIT) || (state == ST_DRAIN);
  assign mem_addr    = fetch_addr;
  assign instr_valid = out_vld;
  assign instr       = instr_q;
  assign opcode      = get_opcode(instr_q);
  assign funct       = get_funct(instr_q);
  assign instr_pc    = ipc_q;
  assign halted      = (state == ST_HALT);

endmodule
